// File: rtl/uncached_axi_bridge.sv
// uncached_axi_bridge: runs uncached SRAM-side fetch/load/store requests as single-beat AXI4 transactions
//   clk, rst                   : clock, synchronous active-high reset
//   inst_*                     : fetch request (addr, ren) and completion (valid pulse, rd data)
//   data_*                     : data request (addr, ren, wen, wd) and completion (valid pulse, rd data)
//   is_cache                   : request belongs to the caches and is ignored here
//   ar*/r*/aw*/w*/b*           : AXI4 master channels, one transaction outstanding at a time
module uncached_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'h0,
    parameter logic [3:0] ID_DATA = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    input  logic        inst_ren,
    output logic        inst_valid,
    output logic [31:0] inst_rd,
    input  logic [31:0] data_addr,
    input  logic        data_ren,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wd,
    output logic        data_valid,
    output logic [31:0] data_rd,
    input  logic        is_cache,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;
    state_t state, state_n;
    logic src_inst;
    logic rd_acc, wr_acc, aw_done, w_done;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arsize  = 3'b010;
    assign awsize  = 3'b010;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign awid    = ID_DATA;
    assign wlast   = 1'b1;
    // data read beats data write beats fetch; a read+write combination is a read
    assign rd_acc  = !is_cache && (data_ren || (inst_ren && data_wen == 4'd0));
    assign wr_acc  = !is_cache && !data_ren && data_wen != 4'd0;
    // each write channel is finished once its valid has dropped or is handshaking now
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid || wready;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = rd_acc ? RADDR : wr_acc ? WREQ : IDLE;
            RADDR:   state_n = arready ? RDATA : RADDR;
            RDATA:   state_n = rvalid ? DONE : RDATA;
            WREQ:    state_n = (aw_done && w_done) ? WRESP : WREQ;
            WRESP:   state_n = bvalid ? DONE : WRESP;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            src_inst   <= 1'b0;
            arid       <= 4'd0;
            araddr     <= 32'd0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= 32'd0;
            awvalid    <= 1'b0;
            wdata      <= 32'd0;
            wstrb      <= 4'd0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            inst_rd    <= 32'd0;
            data_rd    <= 32'd0;
        end else begin
            state      <= state_n;
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_acc) begin
                        src_inst <= !data_ren;
                        arvalid  <= 1'b1;
                        araddr   <= data_ren ? data_addr : inst_addr;
                        arid     <= data_ren ? ID_DATA : ID_INST;
                    end else if (wr_acc) begin
                        src_inst <= 1'b0;
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                        awaddr   <= data_addr;
                        wdata    <= data_wd;
                        wstrb    <= data_wen;
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        inst_valid <= src_inst;
                        data_valid <= !src_inst;
                        if (src_inst) inst_rd <= rdata;
                        else data_rd <= rdata;
                    end
                end
                WREQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    if (aw_done && w_done) bready <= 1'b1;
                end
                WRESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uncached_axi_bridge.sv
// tb_uncached_axi_bridge: directed self-checking bench for uncached_axi_bridge
module tb_uncached_axi_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr, data_addr, data_wd, inst_rd, data_rd;
    logic        inst_ren, inst_valid, data_ren, data_valid, is_cache;
    logic [3:0]  data_wen;
    logic [3:0]  arid, rid, awid, bid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    int errors = 0;
    int checks = 0;

    uncached_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_addr(inst_addr), .inst_ren(inst_ren), .inst_valid(inst_valid), .inst_rd(inst_rd),
        .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen), .data_wd(data_wd),
        .data_valid(data_valid), .data_rd(data_rd), .is_cache(is_cache),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_addr = 0; inst_ren = 0; data_addr = 0; data_ren = 0; data_wen = 0; data_wd = 0;
        is_cache = 0; arready = 1; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 1;
        awready = 1; wready = 1; bid = 1; bresp = 0; bvalid = 1;
        tick(); tick();
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, inst_valid, data_valid}, 0);
        chk("rst_rd", inst_rd | data_rd, 0);
        chk("rst_addr", araddr | awaddr | wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("consts", {arlen, awlen, arsize, awsize, arburst, awburst, wlast}, {8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1});
        rst = 1'b0;
        tick();
        // fetch with no stalls
        inst_ren = 1; inst_addr = 32'h1FC0_0000; rdata = 32'h3C1D_0000;
        tick();
        chk("fetch_arvalid", arvalid, 1);
        chk("fetch_araddr", araddr, 32'h1FC0_0000);
        chk("fetch_arid", arid, 0);
        tick();
        chk("fetch_rready", {arvalid, rready}, 2'b01);
        tick();
        chk("fetch_valid", {inst_valid, data_valid}, 2'b10);
        chk("fetch_rd", inst_rd, 32'h3C1D_0000);
        inst_ren = 0;
        tick();
        chk("fetch_pulse_end", {inst_valid, arvalid}, 0);
        chk("fetch_rd_hold", inst_rd, 32'h3C1D_0000);
        // write with awready stalled two cycles
        awready = 0; wready = 1; bvalid = 0;
        data_wen = 4'b0011; data_addr = 32'h1FAF_0000; data_wd = 32'h0000_BEEF;
        tick();
        chk("wr_c1_valids", {awvalid, wvalid, bready}, 3'b110);
        chk("wr_awaddr", awaddr, 32'h1FAF_0000);
        chk("wr_wdata", wdata, 32'h0000_BEEF);
        chk("wr_wstrb", wstrb, 4'b0011);
        chk("wr_awid", awid, 1);
        data_wen = 0;
        tick();
        chk("wr_c2_valids", {awvalid, wvalid, bready}, 3'b100);
        tick();
        chk("wr_c3_valids", {awvalid, wvalid, bready}, 3'b100);
        awready = 1;
        tick();
        chk("wr_c4_valids", {awvalid, wvalid, bready}, 3'b001);
        awready = 0;
        tick();
        chk("wr_c5_wait_b", {bready, data_valid}, 2'b10);
        bvalid = 1;
        tick();
        chk("wr_done", {bready, data_valid, inst_valid}, 3'b010);
        bvalid = 0; awready = 1;
        tick();
        chk("wr_pulse_end", data_valid, 0);
        // data read takes priority over a simultaneous fetch
        bvalid = 1;
        inst_ren = 1; inst_addr = 32'h1FC0_0100; data_ren = 1; data_addr = 32'hBFD0_0010;
        rdata = 32'h1234_5678;
        tick();
        chk("pri_arid_data", arid, 1);
        chk("pri_araddr_data", araddr, 32'hBFD0_0010);
        tick();
        tick();
        chk("pri_data_valid", {data_valid, inst_valid}, 2'b10);
        chk("pri_data_rd", data_rd, 32'h1234_5678);
        data_ren = 0; rdata = 32'hCAFE_F00D;
        tick();
        chk("pri_idle", {arvalid, inst_valid, data_valid}, 0);
        tick();
        chk("pri_arid_inst", {arvalid, arid}, {1'b1, 4'h0});
        chk("pri_araddr_inst", araddr, 32'h1FC0_0100);
        tick();
        tick();
        chk("pri_inst_valid", {inst_valid, data_valid}, 2'b10);
        chk("pri_inst_rd", inst_rd, 32'hCAFE_F00D);
        chk("pri_data_rd_hold", data_rd, 32'h1234_5678);
        inst_ren = 0;
        tick();
        // cached traffic is ignored
        is_cache = 1; inst_ren = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("cached_quiet", {arvalid, awvalid, wvalid, inst_valid, data_valid}, 0);
        end
        inst_ren = 0; is_cache = 0;
        tick();
        // back-to-back fetches with ren held high, 4-cycle period
        inst_ren = 1; inst_addr = 32'h0000_1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("b2b_arvalid", {arvalid, inst_valid}, 2'b10);
            chk("b2b_araddr", araddr, 32'h0000_1000 + 32'(4 * k));
            rdata = 32'hA000_0000 + 32'(k);
            tick();
            chk("b2b_rready", rready, 1);
            tick();
            chk("b2b_valid", inst_valid, 1);
            chk("b2b_rd", inst_rd, 32'hA000_0000 + 32'(k));
            inst_addr = inst_addr + 32'd4;
            if (k == 3) inst_ren = 0;
            tick();
            chk("b2b_pulse_end", inst_valid, 0);
        end
        tick();
        chk("b2b_stop", arvalid, 0);
        // reset during RDATA abandons the read
        rvalid = 0; inst_ren = 1; inst_addr = 32'h0000_2000; rdata = 32'hDEAD_BEEF;
        tick();
        chk("rstmid_arvalid", arvalid, 1);
        tick();
        chk("rstmid_rready", rready, 1);
        rst = 1; rvalid = 1;
        tick();
        chk("rstmid_after", {rready, inst_valid, arvalid}, 0);
        chk("rstmid_inst_rd", inst_rd, 0);
        rst = 0; inst_ren = 0; rvalid = 0;
        tick();
        chk("rstmid_no_pulse", {inst_valid, arvalid}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uncached_axi_bridge.md
# uncached_axi_bridge

Responder end of the SRAM-like cache-side request interface. It accepts single-word instruction reads and data reads/writes flagged uncached (`is_cache=0`) and runs each one as a single-beat AXI4 transaction. It returns completion as a one-cycle `*_valid` pulse with read data. It sits between the CPU-side SRAM interface and the AXI interconnect, alongside the I/D caches, which serve `is_cache=1` traffic.

## Interface
- `ID_INST`, default 4'h0: ARID used for instruction fetches.
- `ID_DATA`, default 4'h1: ARID/AWID used for data accesses.

Ports:
- `clk` in 1: the single clock; all logic on the posedge.
- `rst` in 1: synchronous, active-high reset.
- `inst_addr` in 32: fetch physical address.
- `inst_ren` in 1: fetch request; held until `inst_valid`.
- `inst_valid` out 1: one-cycle fetch completion pulse.
- `inst_rd` out 32: fetch data; holds until the next fetch completes.
- `data_addr` in 32: data physical address.
- `data_ren` in 1: data read request; held until `data_valid`.
- `data_wen` in 4: byte write enables; nonzero means a write request.
- `data_wd` in 32: write data.
- `data_valid` out 1: one-cycle data completion pulse.
- `data_rd` out 32: data read result; holds until the next data read completes.
- `is_cache` in 1: 1 means the request belongs to the caches and is ignored here.
- `arid` out 4, `araddr` out 32, `arvalid` out 1, `arready` in 1: AXI read address channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI read data channel.
- `awid` out 4, `awaddr` out 32, `awvalid` out 1, `awready` in 1: AXI write address channel.
- `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1: AXI write data channel.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1: AXI write response channel.
- `arlen`/`awlen` out 8, constant 0.
- `arsize`/`awsize` out 3, constant 3'b010.
- `arburst`/`awburst` out 2, constant 2'b01.

## Operation
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE acceptance:
  - Requests are considered only when `is_cache=0`.
  - Priority: `data_ren` first, then `data_wen!=0`, then `inst_ren`. If `data_ren` and `data_wen` are both active, the request is treated as a read.
  - On acceptance, the bridge latches the address, `wen`, `wd`, and a source flag (inst or data).
- Read path:
  - IDLE to RADDR: `arvalid=1`; `araddr`/`arid` come from the latched values.
  - RADDR to RDATA on `arvalid&arready`; `arvalid` drops that edge.
  - RDATA: `rready=1`. On `rvalid&rready`, `rdata` is latched into `inst_rd` or `data_rd` according to the source flag, then the FSM goes to DONE.
- Write path:
  - IDLE to WREQ: `awvalid=1` and `wvalid=1` together; `wstrb=wen`, `wdata=wd`, `wlast=1`.
  - Each valid drops independently after its own handshake. AW and W may complete in either order or in the same cycle.
  - When both have completed, the FSM goes to WRESP with `bready=1`.
  - On `bvalid&bready`, the FSM goes to DONE.
- DONE: the selected `*_valid` is 1 for exactly one cycle, then the FSM returns to IDLE.
- Back-to-back requests: the initiator may keep `ren` high continuously. The level seen in IDLE after DONE is a new request.
- Error responses: `rresp`/`bresp` errors are not reported; the transaction completes normally. `rid`/`bid`/`rlast` are not checked (a single transaction is outstanding).
- Input changes: changes on the request inputs after acceptance are ignored until DONE.

## Timing
- All outputs are registered.
- Reset values: every valid, `rready` and `bready` are 0; `inst_rd`, `data_rd` and `araddr`/`awaddr`/`wdata` are 0; `wstrb` is 0; FSM is IDLE.
- Read latency with `arready=rvalid=1`:
  - Request seen in IDLE at cycle 0.
  - `arvalid` high at cycle 1, handshake at cycle 1.
  - `rready` high at cycle 2, handshake at cycle 2.
  - `*_valid` high at cycle 3.
  - Next acceptance at cycle 4.
- Write latency with all readies and `bvalid=1`:
  - AW and W at cycle 1.
  - `bready` at cycle 2.
  - `data_valid` at cycle 3.
- Wait states stretch each phase by exactly the stall count.
- `*_valid` is never high for more than 1 cycle per accepted request.
- At most one transaction is outstanding.
- `rst` asserted mid-transaction: next edge returns to reset values with no completion pulse. Any partial AXI transaction is abandoned, since reset is system-wide.
- `rst` wins over any simultaneous handshake.

## Test plan
- Fetch: `inst_ren=1`, `inst_addr=0x1FC00000`, `is_cache=0`, `rdata=0x3C1D0000` with no stalls. Required: `araddr=0x1FC00000`, `arid=0` at cycle 1; `inst_valid` at cycle 3; `inst_rd=0x3C1D0000`.
- Write with stalls: `data_wen=4'b0011`, `data_addr=0x1FAF0000`, `wd=0x0000BEEF`; `awready` delayed 2 cycles, `wready` immediate. Required: `wvalid` drops after cycle 1, `awvalid` drops after cycle 3; `bready` from cycle 4; `data_valid` one cycle after `bvalid`; `wstrb=0011`.
- Priority: `inst_ren` and `data_ren` both high. Required: the data read is issued first (`arid=1`); the fetch is issued in the IDLE cycle after the `data_valid` pulse.
- Cached request: `inst_ren=1` with `is_cache=1` for 10 cycles. Required: no AXI valid asserted and no `inst_valid`.
- Back-to-back: `inst_ren` held high with the address stepping +4 after each `inst_valid`. Required: 4 reads complete, one `inst_valid` each, 4-cycle period.
- Reset mid-read: assert `rst` while in RDATA. Required: `rready=0`, no `inst_valid`, `inst_rd=0` on the next cycle.
